// File: rtl/counter_pkg.sv
// Shared definitions for the counter poller: FSM state encoding and default widths.
package counter_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_NUM_CNT    = 4;
    localparam int unsigned DEF_IDX_WIDTH  = 2;
    localparam int unsigned DEF_TIMEOUT    = 16;

    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_REQ  = 3'd1;
    localparam state_t ST_GAP  = 3'd2;
    localparam state_t ST_DONE = 3'd3;
    localparam state_t ST_ERR  = 3'd4;

    // A sweep is in progress while requesting or in the inter-request gap.
    function automatic logic is_busy_state(input state_t s);
        return (s == ST_REQ) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/counter_snapshot_rf.sv
// Snapshot register file: one entry per polled counter, sync write, async read.
module counter_snapshot_rf
    import counter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_CNT    = DEF_NUM_CNT,
    parameter int unsigned IDX_WIDTH  = DEF_IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  rd_sel,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_CNT];
    logic [DATA_WIDTH-1:0] mem_d [NUM_CNT];

    // Next-entry values: only the addressed entry takes the write data.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            mem_d[i] = mem_q[i];
            if (we && (waddr == IDX_WIDTH'(i))) begin
                mem_d[i] = wdata;
            end
        end
    end

    // Entry storage, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read mux; selects beyond the last entry read as zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == IDX_WIDTH'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/counter_poller.sv
// Requester side of the counter read interface: sweeps all indices, snapshots
// each answered count and keeps a running total, aborting an index on timeout.
module counter_poller
    import counter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_CNT    = DEF_NUM_CNT,
    parameter int unsigned IDX_WIDTH  = DEF_IDX_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            valid_cont,
    input  logic [DATA_WIDTH-1:0]           data_cont,
    output logic                            req,
    output logic [IDX_WIDTH-1:0]            idx,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout_err,
    input  logic [IDX_WIDTH-1:0]            rd_sel,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [DATA_WIDTH+IDX_WIDTH-1:0] total
);

    localparam int unsigned TOT_W = DATA_WIDTH + IDX_WIDTH;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CNT - 1);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [TOT_W-1:0]     total_q, total_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 err_q, err_d;
    logic                 req_q, busy_q, done_q;
    logic                 snap_we;

    // Next-state, datapath updates and snapshot write strobe.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        total_d = total_q;
        timer_d = timer_q;
        err_d   = err_q;
        snap_we = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                    idx_d   = '0;
                    total_d = '0;
                    timer_d = '0;
                    err_d   = 1'b0;
                end
            end

            ST_REQ: begin
                if (valid_cont) begin
                    snap_we = 1'b1;
                    total_d = total_q + TOT_W'(data_cont);
                    timer_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_WIDTH'(1);
                        state_d = ST_GAP;
                    end
                end else if (timer_q == TMR_LAST) begin
                    // Flag the abort together with the ERR cycle's done pulse.
                    timer_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            // One cycle with req low so the responder sees a fresh request.
            ST_GAP:  state_d = ST_REQ;

            ST_DONE: state_d = ST_IDLE;

            ST_ERR:  state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            total_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            total_q <= total_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            req_q   <= (state_d == ST_REQ);
            busy_q  <= is_busy_state(state_d);
            done_q  <= (state_d == ST_DONE) || (state_d == ST_ERR);
        end
    end

    counter_snapshot_rf #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_CNT    (NUM_CNT),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_snapshot (
        .clk     (clk),
        .reset   (reset),
        .we      (snap_we),
        .waddr   (idx_q),
        .wdata   (data_cont),
        .rd_sel  (rd_sel),
        .rd_data (rd_data)
    );

    assign req         = req_q;
    assign idx         = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = err_q;
    assign total       = total_q;

endmodule
